// File: rtl/pool_arb_pkg.sv
// Shared types and constants for the layer-2 pool memory port arbiter.
package pool_arb_pkg;

  typedef enum logic [1:0] {
    W_OWN = 2'd0,
    DRAIN = 2'd1,
    R_OWN = 2'd2,
    REL   = 2'd3
  } arb_state_e;

  // Per-port mux selection; SEL_IDLE holds the address and zeroes the strobes.
  typedef enum logic [1:0] {
    SEL_IDLE = 2'd0,
    SEL_WR   = 2'd1,
    SEL_RD   = 2'd2
  } port_sel_e;

  localparam int unsigned DEFAULT_DRAIN_CYCLES = 2;
  localparam int unsigned DRAIN_CNT_WIDTH      = 4;

endpackage

// File: rtl/port_mux_reg.sv
// Registered 2:1 mux for one pool memory port set (address, rden, wren),
// with conflict detection for strobes arriving from the side that lacks ownership.
module port_mux_reg
  import pool_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  port_sel_e             sel_i,
  input  logic                  wr_ok_i,
  input  logic                  rd_ok_i,
  input  logic [ADDR_WIDTH-1:0] wr_address_i,
  input  logic                  wr_rden_i,
  input  logic                  wr_wren_i,
  input  logic [ADDR_WIDTH-1:0] rd_address_i,
  input  logic                  rd_rden_i,
  output logic [ADDR_WIDTH-1:0] mem_address_o,
  output logic                  mem_rden_o,
  output logic                  mem_wren_o,
  output logic                  wr_conflict_o,
  output logic                  rd_conflict_o
);

  logic [ADDR_WIDTH-1:0] address_q, address_d;
  logic                  rden_q, rden_d;
  logic                  wren_q, wren_d;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    address_d = address_q;
    rden_d    = 1'b0;
    wren_d    = 1'b0;
    unique case (sel_i)
      SEL_WR: begin
        address_d = wr_address_i;
        rden_d    = wr_rden_i;
        wren_d    = wr_wren_i;
      end
      SEL_RD: begin
        address_d = rd_address_i;
        rden_d    = rd_rden_i;
      end
      default: ;
    endcase
  end

  assign wr_conflict_o = (wr_rden_i | wr_wren_i) & ~wr_ok_i;
  assign rd_conflict_o = rd_rden_i & ~rd_ok_i;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      address_q <= '0;
      rden_q    <= 1'b0;
      wren_q    <= 1'b0;
    end else begin
      address_q <= address_d;
      rden_q    <= rden_d;
      wren_q    <= wren_d;
    end
  end

  assign mem_address_o = address_q;
  assign mem_rden_o    = rden_q;
  assign mem_wren_o    = wren_q;

endmodule

// File: rtl/pool_port_arbiter_2.sv
// Hands the layer-2 pool memory ports between the layer-2 writer and the
// layer-3 reader: write, drain late writes, grant to reader, release.
module pool_port_arbiter_2
  import pool_arb_pkg::*;
#(
  parameter int unsigned POOL_ADDR_WIDTH = 10,
  parameter int unsigned DRAIN_CYCLES    = DEFAULT_DRAIN_CYCLES, // 1..15
  parameter int unsigned FRAME_CNT_WIDTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       pool_done,
  input  logic [POOL_ADDR_WIDTH-1:0] wr_address_a,
  input  logic [POOL_ADDR_WIDTH-1:0] wr_address_b,
  input  logic                       wr_rden_a,
  input  logic                       wr_rden_b,
  input  logic                       wr_wren_a,
  input  logic                       wr_wren_b,
  input  logic [POOL_ADDR_WIDTH-1:0] rd_address_a,
  input  logic [POOL_ADDR_WIDTH-1:0] rd_address_b,
  input  logic                       rd_rden_a,
  input  logic                       rd_rden_b,
  input  logic                       rd_done,
  output logic [POOL_ADDR_WIDTH-1:0] mem_address_a,
  output logic [POOL_ADDR_WIDTH-1:0] mem_address_b,
  output logic                       mem_rden_a,
  output logic                       mem_rden_b,
  output logic                       mem_wren_a,
  output logic                       mem_wren_b,
  output logic                       layer2_enable,
  output logic                       rd_start,
  output logic                       rd_owned,
  output logic [FRAME_CNT_WIDTH-1:0] frame_count,
  output logic                       err_wr_conflict,
  output logic                       err_rd_conflict
);

  localparam logic [DRAIN_CNT_WIDTH-1:0] DRAIN_LOAD = DRAIN_CNT_WIDTH'(DRAIN_CYCLES - 1);

  arb_state_e                 state_q, state_d;
  logic [DRAIN_CNT_WIDTH-1:0] drain_cnt_q, drain_cnt_d;
  logic                       pool_done_q;
  logic [FRAME_CNT_WIDTH-1:0] frame_count_q, frame_count_d;
  logic                       layer2_enable_q, layer2_enable_d;
  logic                       rd_start_q, rd_start_d;
  logic                       rd_owned_q, rd_owned_d;
  logic                       err_wr_q, err_wr_d;
  logic                       err_rd_q, err_rd_d;

  logic      pd_edge;
  logic      wr_ok, rd_ok;
  port_sel_e port_sel;
  logic      wr_conflict_a, wr_conflict_b, rd_conflict_a, rd_conflict_b;

  assign pd_edge = pool_done & ~pool_done_q;
  assign wr_ok   = (state_q == W_OWN) || (state_q == DRAIN);
  assign rd_ok   = (state_q == R_OWN);

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    unique case (state_q)
      W_OWN: if (pd_edge) begin
        state_d     = DRAIN;
        drain_cnt_d = DRAIN_LOAD;
      end
      DRAIN: if (drain_cnt_q == '0) state_d = R_OWN;
             else drain_cnt_d = drain_cnt_q - DRAIN_CNT_WIDTH'(1);
      R_OWN: if (rd_done) state_d = REL;
      REL:   state_d = W_OWN;
      default: state_d = W_OWN;
    endcase
  end

  // The rd_done cycle already steers to idle so the ports are quiet while in REL.
  always_comb begin
    port_sel = SEL_IDLE;
    if (wr_ok)                port_sel = SEL_WR;
    else if (rd_ok && !rd_done) port_sel = SEL_RD;
  end

  // layer2_enable lags the state by one cycle; REL pre-arms it for the return to W_OWN.
  always_comb begin
    layer2_enable_d = (state_q == W_OWN) || (state_q == REL);
    rd_start_d      = (state_q == DRAIN) && (drain_cnt_q == '0);
    rd_owned_d      = (state_d == R_OWN);
    frame_count_d   = (state_q == REL) ? frame_count_q + FRAME_CNT_WIDTH'(1) : frame_count_q;
    err_wr_d        = err_wr_q | wr_conflict_a | wr_conflict_b;
    err_rd_d        = err_rd_q | rd_conflict_a | rd_conflict_b;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= W_OWN;
      drain_cnt_q     <= '0;
      pool_done_q     <= 1'b0;
      frame_count_q   <= '0;
      layer2_enable_q <= 1'b0;
      rd_start_q      <= 1'b0;
      rd_owned_q      <= 1'b0;
      err_wr_q        <= 1'b0;
      err_rd_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      drain_cnt_q     <= drain_cnt_d;
      pool_done_q     <= pool_done;
      frame_count_q   <= frame_count_d;
      layer2_enable_q <= layer2_enable_d;
      rd_start_q      <= rd_start_d;
      rd_owned_q      <= rd_owned_d;
      err_wr_q        <= err_wr_d;
      err_rd_q        <= err_rd_d;
    end
  end

  port_mux_reg #(.ADDR_WIDTH(POOL_ADDR_WIDTH)) u_port_a (
    .clock         (clock),
    .reset         (reset),
    .sel_i         (port_sel),
    .wr_ok_i       (wr_ok),
    .rd_ok_i       (rd_ok),
    .wr_address_i  (wr_address_a),
    .wr_rden_i     (wr_rden_a),
    .wr_wren_i     (wr_wren_a),
    .rd_address_i  (rd_address_a),
    .rd_rden_i     (rd_rden_a),
    .mem_address_o (mem_address_a),
    .mem_rden_o    (mem_rden_a),
    .mem_wren_o    (mem_wren_a),
    .wr_conflict_o (wr_conflict_a),
    .rd_conflict_o (rd_conflict_a)
  );

  port_mux_reg #(.ADDR_WIDTH(POOL_ADDR_WIDTH)) u_port_b (
    .clock         (clock),
    .reset         (reset),
    .sel_i         (port_sel),
    .wr_ok_i       (wr_ok),
    .rd_ok_i       (rd_ok),
    .wr_address_i  (wr_address_b),
    .wr_rden_i     (wr_rden_b),
    .wr_wren_i     (wr_wren_b),
    .rd_address_i  (rd_address_b),
    .rd_rden_i     (rd_rden_b),
    .mem_address_o (mem_address_b),
    .mem_rden_o    (mem_rden_b),
    .mem_wren_o    (mem_wren_b),
    .wr_conflict_o (wr_conflict_b),
    .rd_conflict_o (rd_conflict_b)
  );

  assign layer2_enable   = layer2_enable_q;
  assign rd_start        = rd_start_q;
  assign rd_owned        = rd_owned_q;
  assign frame_count     = frame_count_q;
  assign err_wr_conflict = err_wr_q;
  assign err_rd_conflict = err_rd_q;

endmodule

// File: tb/tb_pool_port_arbiter_2.sv
// Self-checking bench: a cycle model pushes expected outputs into a scoreboard
// queue as stimulus is driven; directed checks pin the handoff timing landmarks.
module tb_pool_port_arbiter_2;

  localparam int AW = 10;
  localparam int DC = 2;
  localparam int FW = 8;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset, pool_done, rd_done;
  logic [AW-1:0] wr_address_a, wr_address_b, rd_address_a, rd_address_b;
  logic          wr_rden_a, wr_rden_b, wr_wren_a, wr_wren_b, rd_rden_a, rd_rden_b;
  logic [AW-1:0] mem_address_a, mem_address_b;
  logic          mem_rden_a, mem_rden_b, mem_wren_a, mem_wren_b;
  logic          layer2_enable, rd_start, rd_owned, err_wr_conflict, err_rd_conflict;
  logic [FW-1:0] frame_count;

  pool_port_arbiter_2 #(
    .POOL_ADDR_WIDTH (AW),
    .DRAIN_CYCLES    (DC),
    .FRAME_CNT_WIDTH (FW)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .pool_done       (pool_done),
    .wr_address_a    (wr_address_a),
    .wr_address_b    (wr_address_b),
    .wr_rden_a       (wr_rden_a),
    .wr_rden_b       (wr_rden_b),
    .wr_wren_a       (wr_wren_a),
    .wr_wren_b       (wr_wren_b),
    .rd_address_a    (rd_address_a),
    .rd_address_b    (rd_address_b),
    .rd_rden_a       (rd_rden_a),
    .rd_rden_b       (rd_rden_b),
    .rd_done         (rd_done),
    .mem_address_a   (mem_address_a),
    .mem_address_b   (mem_address_b),
    .mem_rden_a      (mem_rden_a),
    .mem_rden_b      (mem_rden_b),
    .mem_wren_a      (mem_wren_a),
    .mem_wren_b      (mem_wren_b),
    .layer2_enable   (layer2_enable),
    .rd_start        (rd_start),
    .rd_owned        (rd_owned),
    .frame_count     (frame_count),
    .err_wr_conflict (err_wr_conflict),
    .err_rd_conflict (err_rd_conflict)
  );

  typedef struct packed {
    logic [AW-1:0] addr_a;
    logic [AW-1:0] addr_b;
    logic          rden_a, rden_b, wren_a, wren_b;
    logic          l2en, rd_start, rd_owned;
    logic [FW-1:0] fcnt;
    logic          err_wr, err_rd;
  } outs_t;

  typedef enum int {M_W, M_D, M_R, M_REL} mstate_e;

  mstate_e m_state = M_W;
  int      m_cnt   = 0;
  logic    m_pd    = 1'b0;
  outs_t   m_out   = '0;
  outs_t   exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  // Expected outputs for the next cycle, from the current inputs and model state.
  task automatic model_step();
    outs_t e;
    bit    wr_phase, rd_phase;
    e = m_out;
    if (reset) begin
      e       = '0;
      m_state = M_W;
      m_cnt   = 0;
      m_pd    = 1'b0;
    end else begin
      wr_phase = (m_state == M_W) || (m_state == M_D);
      rd_phase = (m_state == M_R);
      if (wr_phase) begin
        e.addr_a = wr_address_a; e.addr_b = wr_address_b;
        e.rden_a = wr_rden_a;    e.rden_b = wr_rden_b;
        e.wren_a = wr_wren_a;    e.wren_b = wr_wren_b;
      end else if (rd_phase && !rd_done) begin
        e.addr_a = rd_address_a; e.addr_b = rd_address_b;
        e.rden_a = rd_rden_a;    e.rden_b = rd_rden_b;
        e.wren_a = 1'b0;         e.wren_b = 1'b0;
      end else begin
        e.rden_a = 1'b0; e.rden_b = 1'b0;
        e.wren_a = 1'b0; e.wren_b = 1'b0;
      end
      if (!wr_phase && (wr_rden_a || wr_rden_b || wr_wren_a || wr_wren_b)) e.err_wr = 1'b1;
      if (!rd_phase && (rd_rden_a || rd_rden_b)) e.err_rd = 1'b1;
      e.l2en     = (m_state == M_W) || (m_state == M_REL);
      e.rd_start = 1'b0;
      if (m_state == M_REL) e.fcnt = m_out.fcnt + 8'd1;
      case (m_state)
        M_W:   if (pool_done && !m_pd) begin m_state = M_D; m_cnt = DC - 1; end
        M_D:   if (m_cnt == 0) begin m_state = M_R; e.rd_start = 1'b1; end
               else m_cnt--;
        M_R:   if (rd_done) m_state = M_REL;
        M_REL: m_state = M_W;
        default: m_state = M_W;
      endcase
      e.rd_owned = (m_state == M_R);
      m_pd = pool_done;
    end
    m_out = e;
    exp_q.push_back(e);
  endtask

  // One clock: record expectation, advance, then compare the scoreboard entry.
  task automatic tick();
    outs_t e;
    model_step();
    @(posedge clock);
    #1;
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("sb_mem_address_a", 32'(mem_address_a), 32'(e.addr_a));
      check("sb_mem_address_b", 32'(mem_address_b), 32'(e.addr_b));
      check("sb_mem_rden_a",    32'(mem_rden_a),    32'(e.rden_a));
      check("sb_mem_rden_b",    32'(mem_rden_b),    32'(e.rden_b));
      check("sb_mem_wren_a",    32'(mem_wren_a),    32'(e.wren_a));
      check("sb_mem_wren_b",    32'(mem_wren_b),    32'(e.wren_b));
      check("sb_layer2_enable", 32'(layer2_enable), 32'(e.l2en));
      check("sb_rd_start",      32'(rd_start),      32'(e.rd_start));
      check("sb_rd_owned",      32'(rd_owned),      32'(e.rd_owned));
      check("sb_frame_count",   32'(frame_count),   32'(e.fcnt));
      check("sb_err_wr",        32'(err_wr_conflict), 32'(e.err_wr));
      check("sb_err_rd",        32'(err_rd_conflict), 32'(e.err_rd));
    end
  endtask

  task automatic clear_strobes();
    wr_rden_a = 1'b0; wr_rden_b = 1'b0; wr_wren_a = 1'b0; wr_wren_b = 1'b0;
    rd_rden_a = 1'b0; rd_rden_b = 1'b0; rd_done = 1'b0;
  endtask

  // Quick frame: edge, drain, grant, release; ends back in W_OWN.
  task automatic run_frame();
    pool_done = 1'b1;
    tick();
    pool_done = 1'b0;
    repeat (DC) tick();
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; pool_done = 1'b0;
    wr_address_a = '0; wr_address_b = '0; rd_address_a = '0; rd_address_b = '0;
    clear_strobes();

    // Reset release
    repeat (3) begin
      tick();
      check("rst_l2en", 32'(layer2_enable), 32'd0);
      check("rst_fcnt", 32'(frame_count), 32'd0);
    end
    reset = 1'b0;
    tick();
    check("rel_l2en", 32'(layer2_enable), 32'd1);

    // Write passthrough
    wr_address_a = 10'h155; wr_wren_a = 1'b1;
    tick();
    check("wp_addr", 32'(mem_address_a), 32'h155);
    check("wp_wren", 32'(mem_wren_a), 32'd1);
    clear_strobes();

    // Full handoff: observe t0+1 .. t0+DC+2
    pool_done = 1'b1;
    for (int i = 1; i <= DC + 2; i++) begin
      tick();
      pool_done = 1'b0;
      check("ho_rd_start", 32'(rd_start), 32'(i == DC + 1));
      check("ho_l2en",     32'(layer2_enable), 32'(i < 2));
      check("ho_rd_owned", 32'(rd_owned), 32'(i >= DC + 1));
    end
    rd_address_b = 10'h3FF; rd_rden_b = 1'b1;
    tick();
    check("rd_rden_b", 32'(mem_rden_b), 32'd1);
    check("rd_addr_b", 32'(mem_address_b), 32'h3FF);
    clear_strobes();

    // Writer conflict in R_OWN, sticky
    wr_address_a = 10'h0AA; wr_wren_a = 1'b1;
    tick();
    check("cw_wren_a", 32'(mem_wren_a), 32'd0);
    check("cw_err",    32'(err_wr_conflict), 32'd1);
    clear_strobes();
    tick();
    check("cw_sticky", 32'(err_wr_conflict), 32'd1);

    // Extra pool_done edge in R_OWN is ignored
    pool_done = 1'b1; tick();
    pool_done = 1'b0; tick();
    tick();
    check("xpd_owned", 32'(rd_owned), 32'd1);
    check("xpd_start", 32'(rd_start), 32'd0);

    // Release, with a reader strobe alongside rd_done
    rd_done = 1'b1; rd_rden_a = 1'b1;
    tick();
    check("rl_rden_a", 32'(mem_rden_a), 32'd0);
    check("rl_owned",  32'(rd_owned), 32'd0);
    check("rl_l2en",   32'(layer2_enable), 32'd0);
    clear_strobes();
    tick();
    check("rl_l2en2", 32'(layer2_enable), 32'd1);
    check("rl_fcnt",  32'(frame_count), 32'd1);

    // Reader conflict in W_OWN
    rd_rden_a = 1'b1;
    tick();
    check("cr_err",    32'(err_rd_conflict), 32'd1);
    check("cr_rden_a", 32'(mem_rden_a), 32'd0);
    clear_strobes();

    // Level-high pool_done across REL->W_OWN does not retrigger
    pool_done = 1'b1;
    tick();
    repeat (DC) tick();
    rd_done = 1'b1; tick();
    rd_done = 1'b0; tick();
    repeat (4) begin
      tick();
      check("lvl_l2en",  32'(layer2_enable), 32'd1);
      check("lvl_owned", 32'(rd_owned), 32'd0);
    end
    pool_done = 1'b0;
    tick();

    // Reset in DRAIN
    pool_done = 1'b1; tick();
    pool_done = 1'b0; reset = 1'b1; tick();
    reset = 1'b0;
    repeat (4) begin
      tick();
      check("rd_start_nopulse", 32'(rd_start), 32'd0);
      check("rd_err_wr", 32'(err_wr_conflict), 32'd0);
      check("rd_err_rd", 32'(err_rd_conflict), 32'd0);
      check("rd_fcnt",   32'(frame_count), 32'd0);
    end

    // Simultaneous rd_done and writer strobe in R_OWN
    pool_done = 1'b1; tick();
    pool_done = 1'b0; repeat (DC) tick();
    rd_done = 1'b1; wr_wren_b = 1'b1; wr_address_b = 10'h123;
    tick();
    check("sim_wren_b", 32'(mem_wren_b), 32'd0);
    check("sim_err_wr", 32'(err_wr_conflict), 32'd1);
    check("sim_owned",  32'(rd_owned), 32'd0);
    clear_strobes();
    tick();
    check("sim_fcnt", 32'(frame_count), 32'd1);

    // Frame counter wrap
    reset = 1'b1; tick(); tick();
    reset = 1'b0; tick();
    for (int f = 0; f < 255; f++) run_frame();
    check("wrap_255", 32'(frame_count), 32'd255);
    run_frame();
    check("wrap_0", 32'(frame_count), 32'd0);

    // Random traffic against the model
    for (int c = 0; c < 1500; c++) begin
      reset        = ($urandom_range(0, 199) == 0);
      pool_done    = ($urandom_range(0, 5) == 0);
      rd_done      = ($urandom_range(0, 3) == 0);
      wr_address_a = AW'($urandom);
      wr_address_b = AW'($urandom);
      rd_address_a = AW'($urandom);
      rd_address_b = AW'($urandom);
      wr_rden_a    = ($urandom_range(0, 7) == 0);
      wr_rden_b    = ($urandom_range(0, 7) == 0);
      wr_wren_a    = ($urandom_range(0, 3) == 0);
      wr_wren_b    = ($urandom_range(0, 3) == 0);
      rd_rden_a    = ($urandom_range(0, 3) == 0);
      rd_rden_b    = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
